// File: rtl/xor_gate3_pkg.sv
// ---------------------------------------------------------------------------
// xor_gate3_pkg
//   Shared constants and helpers for the three-input XOR primitive.
//   - XOR3_DEFAULT_WIDTH : default lane count of xor_gate3
//   - XOR3_CNT_W         : width of the optional f_q[0] toggle counter
//   - XOR3_CNT_MAX       : saturation value of that counter
//   - xor3_sat_inc()     : increment that sticks at XOR3_CNT_MAX
// ---------------------------------------------------------------------------
package xor_gate3_pkg;

    localparam int XOR3_DEFAULT_WIDTH = 1;
    localparam int XOR3_CNT_W         = 16;
    localparam logic [XOR3_CNT_W-1:0] XOR3_CNT_MAX = 16'hFFFF;

    // Saturating increment: holds at the maximum instead of wrapping to 0.
    function automatic logic [XOR3_CNT_W-1:0] xor3_sat_inc(
        input logic [XOR3_CNT_W-1:0] v
    );
        if (v == XOR3_CNT_MAX)
            return v;
        return v + {{(XOR3_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/xor3_cell.sv
// ---------------------------------------------------------------------------
// xor3_cell
//   One lane of the three-input XOR: y = a ^ b ^ c, purely combinational.
//   An X/Z on any input yields X on y only; neighbouring lanes are separate
//   instances and are never affected.
// Ports
//   a, b, c : in  1   operands
//   y       : out 1   odd-parity of {a, b, c}
// ---------------------------------------------------------------------------
module xor3_cell
    import xor_gate3_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = a ^ b ^ c;

endmodule

// File: rtl/xor_gate3.sv
// ---------------------------------------------------------------------------
// xor_gate3
//   WIDTH-lane three-input XOR used as a parity / odd-count primitive.
//   f is combinational and tracks the inputs at all times (including during
//   reset and with no clock). f_q is a retimed copy for synchronous consumers.
//
//   Optional feature, enabled by defining XOR_GATE3_TOGGLE_CNT_EN:
//     a 16-bit saturating counter of f_q[0] transitions, exposed on toggle_cnt.
//     Without the macro the port and counter do not exist.
//
// Ports
//   clk        : in  1      rising-edge clock
//   rst        : in  1      synchronous, active-high reset (clears f_q, counter)
//   a, b, c    : in  WIDTH  operands
//   f          : out WIDTH  a ^ b ^ c, zero latency
//   f_q        : out WIDTH  f registered, one cycle latency
//   toggle_cnt : out 16     f_q[0] transition count (macro builds only)
// ---------------------------------------------------------------------------
module xor_gate3
    import xor_gate3_pkg::*;
#(
    parameter int WIDTH = XOR3_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [WIDTH-1:0]      c,
    output logic [WIDTH-1:0]      f,
    output logic [WIDTH-1:0]      f_q
`ifdef XOR_GATE3_TOGGLE_CNT_EN
    ,
    output logic [XOR3_CNT_W-1:0] toggle_cnt
`endif
);

    // One independent cell per lane keeps X propagation strictly per lane.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        xor3_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .c (c[i]),
            .y (f[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            f_q <= '0;
        else
            f_q <= f;
    end

`ifdef XOR_GATE3_TOGGLE_CNT_EN
    logic [XOR3_CNT_W-1:0] cnt_q;

    // A transition of f_q[0] happens exactly when the value about to be
    // registered differs from the current one, so count on that condition.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (f[0] != f_q[0])
            cnt_q <= xor3_sat_inc(cnt_q);
    end

    assign toggle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_xor_gate3.sv
// ---------------------------------------------------------------------------
// tb_xor_gate3
//   Directed bench for xor_gate3 with a 1-lane and a 4-lane instance.
//   Builds with or without XOR_GATE3_TOGGLE_CNT_EN; counter checks only
//   exist in the macro build, all f / f_q checks run in both.
// ---------------------------------------------------------------------------
module tb_xor_gate3;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b1;
    logic       a1, b1, c1;
    logic       f1, fq1;
    logic [3:0] a4, b4, c4;
    logic [3:0] f4, fq4;
`ifdef XOR_GATE3_TOGGLE_CNT_EN
    logic [15:0] tc1, tc4;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    xor_gate3 #(.WIDTH(1)) u1 (
        .clk (clk), .rst (rst),
        .a (a1), .b (b1), .c (c1),
        .f (f1), .f_q (fq1)
`ifdef XOR_GATE3_TOGGLE_CNT_EN
        , .toggle_cnt (tc1)
`endif
    );

    xor_gate3 #(.WIDTH(4)) u4 (
        .clk (clk), .rst (rst),
        .a (a4), .b (b4), .c (c4),
        .f (f4), .f_q (fq4)
`ifdef XOR_GATE3_TOGGLE_CNT_EN
        , .toggle_cnt (tc4)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set1(input logic [2:0] abc);
        {a1, b1, c1} = abc;
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] abc;
        logic       f;
    } vec1_t;

    typedef struct {
        logic [3:0] a, b, c;
        logic [3:0] f;
    } vec4_t;

    vec1_t tv1[8];
    vec4_t tv4[4];

    initial begin
        // Truth table, hand-written: abc 000..111 -> 0,1,1,0,1,0,0,1
        tv1[0] = '{3'b000, 1'b0};
        tv1[1] = '{3'b001, 1'b1};
        tv1[2] = '{3'b010, 1'b1};
        tv1[3] = '{3'b011, 1'b0};
        tv1[4] = '{3'b100, 1'b1};
        tv1[5] = '{3'b101, 1'b0};
        tv1[6] = '{3'b110, 1'b0};
        tv1[7] = '{3'b111, 1'b1};

        tv4[0] = '{4'b1100, 4'b1010, 4'b1001, 4'b1111};
        tv4[1] = '{4'b0000, 4'b1111, 4'b0101, 4'b1010};
        tv4[2] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111};
        tv4[3] = '{4'b0011, 4'b0101, 4'b0000, 4'b0110};

        set1(3'b000);
        a4 = '0; b4 = '0; c4 = '0;

        // Combinational path with the clock stopped.
        for (int i = 0; i < 8; i++) begin
            set1(tv1[i].abc);
            #100;
            chk($sformatf("comb_f1_abc%03b", tv1[i].abc), {31'd0, f1}, {31'd0, tv1[i].f});
        end
        for (int i = 0; i < 4; i++) begin
            a4 = tv4[i].a; b4 = tv4[i].b; c4 = tv4[i].c;
            #100;
            chk($sformatf("comb_f4_%0d", i), {28'd0, f4}, {28'd0, tv4[i].f});
        end

        // Start clock, reset with abc=001: f must track during reset.
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        set1(3'b001);
        edge_sample();
        chk("reset_fq1", {31'd0, fq1}, 32'd0);
        chk("reset_fq4", {28'd0, fq4}, 32'd0);
        chk("reset_f1_tracks", {31'd0, f1}, 32'd1);
`ifdef XOR_GATE3_TOGGLE_CNT_EN
        chk("reset_tc1", {16'd0, tc1}, 32'd0);
        chk("reset_tc4", {16'd0, tc4}, 32'd0);
`endif

        // Registered path: 0 before the edge, 1 after.
        @(negedge clk);
        rst = 1'b0;
        chk("reg_fq1_before", {31'd0, fq1}, 32'd0);
        edge_sample();
        chk("reg_fq1_after", {31'd0, fq1}, 32'd1);

        // Mid-operation reset with abc=111.
        @(negedge clk);
        set1(3'b111);
        edge_sample();
        chk("pre_rst_fq1", {31'd0, fq1}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_f1_during", {31'd0, f1}, 32'd1);
        edge_sample();
        chk("rst_fq1_cleared", {31'd0, fq1}, 32'd0);
        chk("rst_f1_after_edge", {31'd0, f1}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        chk("post_rst_fq1", {31'd0, fq1}, 32'd1);

        // 4-lane registered path.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a4 = tv4[i].a; b4 = tv4[i].b; c4 = tv4[i].c;
            #1;
            chk($sformatf("w4_f_now_%0d", i), {28'd0, f4}, {28'd0, tv4[i].f});
            edge_sample();
            chk($sformatf("w4_fq_%0d", i), {28'd0, fq4}, {28'd0, tv4[i].f});
        end

        // Toggle sequence: reset, hold 000, then alternate 001/000 ten times.
        @(negedge clk);
        rst = 1'b1;
        set1(3'b000);
        edge_sample();
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        chk("tog_fq1_start", {31'd0, fq1}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set1((i % 2 == 0) ? 3'b001 : 3'b000);
            edge_sample();
            chk($sformatf("tog_fq1_%0d", i), {31'd0, fq1}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
`ifdef XOR_GATE3_TOGGLE_CNT_EN
        chk("tog_cnt_10", {16'd0, tc1}, 32'd10);

        // Preload the counter at its ceiling, then toggle: it must hold.
        @(negedge clk);
        force u1.cnt_q = 16'hFFFF;
        #1;
        release u1.cnt_q;
        set1(3'b001);
        edge_sample();
        chk("tog_fq1_sat", {31'd0, fq1}, 32'd1);
        chk("tog_cnt_sat1", {16'd0, tc1}, 32'h0000FFFF);
        @(negedge clk);
        set1(3'b000);
        edge_sample();
        chk("tog_cnt_sat2", {16'd0, tc1}, 32'h0000FFFF);

        // Reset beats increment: input differs from f_q while rst=1.
        @(negedge clk);
        rst = 1'b1;
        set1(3'b001);
        edge_sample();
        chk("tog_cnt_rst", {16'd0, tc1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end

endmodule
